// File: rtl/piso_bit_feeder.sv
// Parallel-in/serial-out feeder for the serial sequence detector.
// Optional trailing even-parity bit per word: define PISO_PARITY_EN.
module piso_bit_feeder #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_start,
  output logic             busy
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [CW-1:0]    cnt_q;
  logic             ser_q;
  logic             sv_q;
  logic             fs_q;
  logic             accept;
`ifdef PISO_PARITY_EN
  logic             par_q;
`endif

  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  always_comb begin
    sreg_d = sreg_q;
    if (MSB_FIRST)
      sreg_d = {sreg_q[WIDTH-2:0], 1'b0};
    else
      sreg_d = {1'b0, sreg_q[WIDTH-1:1]};
  end

  always_comb begin
    data_ready = 1'b0;
    unique case (state_q)
      IDLE:   data_ready = 1'b1;
`ifdef PISO_PARITY_EN
      SHIFT:  data_ready = 1'b0;
      PARITY: data_ready = 1'b1;
`else
      SHIFT:  data_ready = (cnt_q == '0);
`endif
      default: data_ready = 1'b0;
    endcase
    if (rst)
      data_ready = 1'b0;
  end

  assign accept = data_valid && data_ready;

  // Accept is only possible where a load is legal, so it takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      ser_q   <= 1'b0;
      sv_q    <= 1'b0;
      fs_q    <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (accept) begin
      state_q <= SHIFT;
      sreg_q  <= data_in;
      cnt_q   <= CW'(WIDTH - 1);
      ser_q   <= lead_bit(data_in);
      sv_q    <= 1'b1;
      fs_q    <= 1'b1;
`ifdef PISO_PARITY_EN
      par_q   <= ^data_in;
`endif
    end else begin
      fs_q <= 1'b0;
      unique case (state_q)
        SHIFT: begin
          if (cnt_q != '0) begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_q - 1'b1;
            ser_q  <= lead_bit(sreg_d);
            sv_q   <= 1'b1;
          end else begin
`ifdef PISO_PARITY_EN
            state_q <= PARITY;
            ser_q   <= par_q;
            sv_q    <= 1'b1;
`else
            state_q <= IDLE;
            ser_q   <= 1'b0;
            sv_q    <= 1'b0;
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          ser_q   <= 1'b0;
          sv_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ser_out     = ser_q;
  assign ser_valid   = sv_q;
  assign frame_start = fs_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_piso_bit_feeder.sv
// Directed table-driven bench for piso_bit_feeder (WIDTH=8).
// Covers MSB/LSB order, back-to-back words, mid-word reset.
module tb_piso_bit_feeder;

`ifdef PISO_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  typedef struct {
    logic       rst;
    logic       v;
    logic [7:0] d;
    logic       ser;
    logic       sv;
    logic       fs;
    logic       bsy;
    logic       rdy;
  } vec_t;

  vec_t tbl[$];

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       dv  = 1'b0;
  logic       rdy, ser, sv, fs, bsy;
  logic [7:0] din_l = '0;
  logic       dv_l  = 1'b0;
  logic       rdy_l, ser_l, sv_l, fs_l, bsy_l;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  piso_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .data_in(din), .data_valid(dv),
    .data_ready(rdy), .ser_out(ser), .ser_valid(sv),
    .frame_start(fs), .busy(bsy)
  );

  piso_bit_feeder #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .data_in(din_l), .data_valid(dv_l),
    .data_ready(rdy_l), .ser_out(ser_l), .ser_valid(sv_l),
    .frame_start(fs_l), .busy(bsy_l)
  );

  task automatic chk(input string nm, input int idx,
                     input logic act, input logic exp);
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[%0d]: got %b want %b", nm, idx, act, exp);
    end
  endtask

  function automatic void push(input logic r, input logic v,
                               input logic [7:0] d, input logic s,
                               input logic q, input logic f,
                               input logic b, input logic y);
    vec_t e;
    e.rst = r; e.v = v; e.d = d; e.ser = s;
    e.sv = q; e.fs = f; e.bsy = b; e.rdy = y;
    tbl.push_back(e);
  endfunction

  // One word MSB first; hold keeps data_valid high on non-ready cycles.
  function automatic void add_word(input logic [7:0] w, input logic hold);
    for (int i = 0; i < 8; i++)
      push(1'b0, (i == 0) ? 1'b1 : hold, w, w[7-i], 1'b1,
           (i == 0), 1'b1, (i == 7) && !PAR);
    if (PAR)
      push(1'b0, hold, w, ^w, 1'b1, 1'b0, 1'b1, 1'b1);
  endfunction

  function automatic void idle_row();
    push(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    push(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_row();
    add_word(8'hA4, 1'b0);
    idle_row();
    add_word(8'hFF, 1'b1);
    add_word(8'h00, 1'b1);
    idle_row();
    add_word(8'h92, 1'b0);
    idle_row();
    push(1'b0, 1'b1, 8'hF0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    push(1'b0, 1'b0, 8'hF0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    push(1'b0, 1'b0, 8'hF0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    push(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle_row();
    add_word(8'h0F, 1'b0);
    idle_row();

    foreach (tbl[i]) begin
      rst = tbl[i].rst;
      dv  = tbl[i].v;
      din = tbl[i].d;
      step();
      nvec++;
      chk("ser_out", i, ser, tbl[i].ser);
      chk("ser_valid", i, sv, tbl[i].sv);
      chk("frame_start", i, fs, tbl[i].fs);
      chk("busy", i, bsy, tbl[i].bsy);
      chk("data_ready", i, rdy, tbl[i].rdy);
    end

    // LSB-first instance: 0x01 gives 1 then seven 0s.
    dv_l  = 1'b1;
    din_l = 8'h01;
    step();
    nvec++;
    chk("lsb_ser", 0, ser_l, 1'b1);
    chk("lsb_fs", 0, fs_l, 1'b1);
    chk("lsb_sv", 0, sv_l, 1'b1);
    dv_l = 1'b0;
    for (int i = 1; i < 8; i++) begin
      step();
      nvec++;
      chk("lsb_ser", i, ser_l, 1'b0);
      chk("lsb_sv", i, sv_l, 1'b1);
      chk("lsb_fs", i, fs_l, 1'b0);
    end
    if (PAR) begin
      step();
      nvec++;
      chk("lsb_par", 8, ser_l, 1'b1);
      chk("lsb_par_sv", 8, sv_l, 1'b1);
    end
    step();
    nvec++;
    chk("lsb_end_sv", 0, sv_l, 1'b0);
    chk("lsb_end_busy", 0, bsy_l, 1'b0);
    chk("lsb_end_rdy", 0, rdy_l, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
